// File: rtl/disp_pkg.sv
// Shared display definitions: digit word layout, blank digit, character codes
// and the button debounce state encoding.
package disp_pkg;

  localparam int unsigned DISP_CHAR_W = 5;
  localparam int unsigned DISP_DIG_W  = DISP_CHAR_W + 2;

  // Digit word is {en, char, dp}.
  typedef logic [DISP_DIG_W-1:0] digit_t;

  localparam digit_t DIGIT_BLANK = '0;

  localparam logic [DISP_CHAR_W-1:0] CH_0     = 5'd0;
  localparam logic [DISP_CHAR_W-1:0] CH_1     = 5'd1;
  localparam logic [DISP_CHAR_W-1:0] CH_2     = 5'd2;
  localparam logic [DISP_CHAR_W-1:0] CH_3     = 5'd3;
  localparam logic [DISP_CHAR_W-1:0] CH_4     = 5'd4;
  localparam logic [DISP_CHAR_W-1:0] CH_5     = 5'd5;
  localparam logic [DISP_CHAR_W-1:0] CH_6     = 5'd6;
  localparam logic [DISP_CHAR_W-1:0] CH_7     = 5'd7;
  localparam logic [DISP_CHAR_W-1:0] CH_8     = 5'd8;
  localparam logic [DISP_CHAR_W-1:0] CH_9     = 5'd9;
  localparam logic [DISP_CHAR_W-1:0] CH_A     = 5'd10;
  localparam logic [DISP_CHAR_W-1:0] CH_B     = 5'd11;
  localparam logic [DISP_CHAR_W-1:0] CH_C     = 5'd12;
  localparam logic [DISP_CHAR_W-1:0] CH_D     = 5'd13;
  localparam logic [DISP_CHAR_W-1:0] CH_E     = 5'd14;
  localparam logic [DISP_CHAR_W-1:0] CH_F     = 5'd15;
  localparam logic [DISP_CHAR_W-1:0] CH_DASH  = 5'd16;
  localparam logic [DISP_CHAR_W-1:0] CH_SPACE = 5'd31;

  typedef enum logic [1:0] {
    StIdleLow,
    StWaitHigh,
    StIdleHigh,
    StWaitLow
  } deb_state_e;

  function automatic digit_t mk_digit(input logic en, input logic [DISP_CHAR_W-1:0] ch,
                                      input logic dp);
    return {en, ch, dp};
  endfunction

endpackage

// File: rtl/display_msg_sequencer_if.sv
// Connection bundle between the game/top logic and the message sequencer:
// raw controls, table write port and the displayed frame.
interface display_msg_sequencer_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned NUM_MSGS   = 5,
  parameter int unsigned CHAR_W     = 5
);

  localparam int unsigned DIG_W    = CHAR_W + 2;
  localparam int unsigned MSG_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int unsigned DIGIDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                        confirma;
  logic                        dir;
  logic                        auto_mode;
  logic                        wr_en;
  logic [MSG_W-1:0]            wr_msg;
  logic [DIGIDX_W-1:0]         wr_digit;
  logic [DIG_W-1:0]            wr_data;
  logic [NUM_DIGITS*DIG_W-1:0] digits;
  logic [MSG_W-1:0]            msg_idx;
  logic                        step;

  modport master (
    output confirma, dir, auto_mode, wr_en, wr_msg, wr_digit, wr_data,
    input  digits, msg_idx, step
  );

  modport slave (
    input  confirma, dir, auto_mode, wr_en, wr_msg, wr_digit, wr_data,
    output digits, msg_idx, step
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a 4-state debounce
// FSM that emits a single-cycle press pulse per accepted press.
module btn_debounce
  import disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  deb_state_e state_q;
  logic [CntW-1:0] cnt_q;
  logic       press_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Release is debounced like a press so a bouncy release cannot re-trigger.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        StIdleLow: begin
          if (sync2_q) begin
            state_q <= StWaitHigh;
            cnt_q   <= '0;
          end
        end
        StWaitHigh: begin
          if (!sync2_q) begin
            state_q <= StIdleLow;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdleHigh;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIdleHigh: begin
          if (!sync2_q) begin
            state_q <= StWaitLow;
            cnt_q   <= '0;
          end
        end
        StWaitLow: begin
          if (sync2_q) begin
            state_q <= StIdleHigh;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdleLow;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdleLow;
      endcase
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_msg_sequencer.sv
// Message sequencer: writable table of display frames, stepped by a debounced
// button or an auto-advance timer, forward or backward with wrap-around.
module display_msg_sequencer
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned NUM_MSGS        = 5,
  parameter int unsigned CHAR_W          = DISP_CHAR_W,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 100000000
) (
  input logic                    clock,
  input logic                    reset,
  display_msg_sequencer_if.slave bus
);

  localparam int unsigned DIG_W   = CHAR_W + 2;
  localparam int unsigned MsgW    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int unsigned DigIdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TimW    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [TimW-1:0] TimLast = TimW'(AUTO_PERIOD - 1);
  localparam logic [MsgW-1:0] MsgLast = MsgW'(NUM_MSGS - 1);

  logic dir_s1_q, dir_q;
  logic auto_s1_q, auto_q;
  logic press;
  logic tick;
  logic step_req;
  logic msg_ok, dig_ok;

  logic [TimW-1:0] timer_q, timer_d;
  logic [MsgW-1:0] idx_q, idx_d;
  logic            step_q;

  logic [NUM_DIGITS-1:0][DIG_W-1:0] table_q [NUM_MSGS];
  logic [NUM_DIGITS-1:0][DIG_W-1:0] digits_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirma_deb (
    .clock(clock),
    .reset(reset),
    .btn  (bus.confirma),
    .press(press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_s1_q  <= 1'b0;
      dir_q     <= 1'b0;
      auto_s1_q <= 1'b0;
      auto_q    <= 1'b0;
    end else begin
      dir_s1_q  <= bus.dir;
      dir_q     <= dir_s1_q;
      auto_s1_q <= bus.auto_mode;
      auto_q    <= auto_s1_q;
    end
  end

  // Range checks only exist when the index field can encode unused values.
  if (NUM_MSGS == (2 ** MsgW)) begin : g_msg_full
    assign msg_ok = 1'b1;
  end else begin : g_msg_part
    assign msg_ok = (bus.wr_msg < MsgW'(NUM_MSGS));
  end

  if (NUM_DIGITS == (2 ** DigIdxW)) begin : g_dig_full
    assign dig_ok = 1'b1;
  end else begin : g_dig_part
    assign dig_ok = (bus.wr_digit < DigIdxW'(NUM_DIGITS));
  end

  always_comb begin
    tick     = auto_q && (timer_q == TimLast);
    step_req = press || tick;

    timer_d = timer_q + 1'b1;
    if (!auto_q || press || tick) begin
      timer_d = '0;
    end

    idx_d = idx_q;
    if (step_req) begin
      if (dir_q) begin
        idx_d = (idx_q == '0) ? MsgLast : idx_q - 1'b1;
      end else begin
        idx_d = (idx_q == MsgLast) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      idx_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      step_q  <= step_req;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      table_q <= '{default: '0};
    end else if (bus.wr_en && msg_ok && dig_ok) begin
      table_q[bus.wr_msg][bus.wr_digit] <= bus.wr_data;
    end
  end

  // Reloaded every cycle so writes to the shown frame appear without a step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits_q <= '0;
    end else begin
      digits_q <= table_q[idx_q];
    end
  end

  assign bus.digits  = digits_q;
  assign bus.msg_idx = idx_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_display_msg_sequencer.sv
// Directed bench for display_msg_sequencer with short debounce and auto periods.
module tb_display_msg_sequencer;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NUM_MSGS   = 3;
  localparam int unsigned CHAR_W     = 5;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   step_cnt = 0;
  int   base;

  always #5 clock = ~clock;

  display_msg_sequencer_if #(
    .NUM_DIGITS(NUM_DIGITS),
    .NUM_MSGS  (NUM_MSGS),
    .CHAR_W    (CHAR_W)
  ) bus ();

  display_msg_sequencer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .NUM_MSGS       (NUM_MSGS),
    .CHAR_W         (CHAR_W),
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always @(negedge clock) begin
    if (bus.step === 1'b1) step_cnt <= step_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full press: held long enough to debounce, then released and settled.
  task automatic press_btn();
    bus.confirma = 1'b1;
    cyc(8);
    bus.confirma = 1'b0;
    cyc(10);
  endtask

  initial begin
    reset         = 1'b0;
    bus.confirma  = 1'b0;
    bus.dir       = 1'b0;
    bus.auto_mode = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_msg    = '0;
    bus.wr_digit  = '0;
    bus.wr_data   = '0;
    cyc(3);
    check("reset_idx", 64'(bus.msg_idx), 64'd0);
    check("reset_digits", 64'(bus.digits), 64'd0);
    check("reset_step", 64'(bus.step), 64'd0);
    reset = 1'b1;

    // 1: write frame 1 digit 0, single press
    bus.wr_en = 1'b1; bus.wr_msg = 2'd1; bus.wr_digit = 3'd0; bus.wr_data = 7'h4B;
    cyc(1);
    bus.wr_en = 1'b0;
    check("t1_digits_frame0", 64'(bus.digits), 64'd0);
    base = step_cnt;
    bus.confirma = 1'b1;
    cyc(7);
    check("t1_idx_before", 64'(bus.msg_idx), 64'd0);
    cyc(1);
    check("t1_idx_after", 64'(bus.msg_idx), 64'd1);
    check("t1_step_pulse", 64'(bus.step), 64'd1);
    check("t1_digits_lag", 64'(bus.digits), 64'd0);
    cyc(1);
    check("t1_digits", 64'(bus.digits), 64'h4B);
    check("t1_step_low", 64'(bus.step), 64'd0);
    cyc(2);
    bus.confirma = 1'b0;
    cyc(10);
    check("t1_one_step", 64'(step_cnt - base), 64'd1);

    // 2: bounce never reaches the debounce count
    base = step_cnt;
    repeat (5) begin
      bus.confirma = 1'b1; cyc(2);
      bus.confirma = 1'b0; cyc(2);
    end
    cyc(10);
    check("t2_no_step", 64'(step_cnt - base), 64'd0);
    check("t2_idx", 64'(bus.msg_idx), 64'd1);

    // 3: forward and backward wrap
    base = step_cnt;
    press_btn(); check("t3_fwd_2", 64'(bus.msg_idx), 64'd2);
    press_btn(); check("t3_fwd_wrap0", 64'(bus.msg_idx), 64'd0);
    check("t3_digits_f0", 64'(bus.digits), 64'd0);
    press_btn(); check("t3_fwd_1", 64'(bus.msg_idx), 64'd1);
    check("t3_digits_f1", 64'(bus.digits), 64'h4B);
    bus.dir = 1'b1; cyc(3);
    press_btn(); check("t3_bwd_0", 64'(bus.msg_idx), 64'd0);
    press_btn(); check("t3_bwd_wrap2", 64'(bus.msg_idx), 64'd2);
    bus.dir = 1'b0; cyc(3);
    check("t3_steps", 64'(step_cnt - base), 64'd5);

    // 4: auto advance every 10 cycles
    bus.auto_mode = 1'b1;
    cyc(11);
    check("t4_before_tick", 64'(bus.msg_idx), 64'd2);
    cyc(1);
    check("t4_tick1_idx", 64'(bus.msg_idx), 64'd0);
    check("t4_tick1_step", 64'(bus.step), 64'd1);
    cyc(9);
    check("t4_mid_period", 64'(bus.msg_idx), 64'd0);
    check("t4_mid_step", 64'(bus.step), 64'd0);
    cyc(1);
    check("t4_tick2_idx", 64'(bus.msg_idx), 64'd1);
    cyc(2);
    // press_req lands in the same cycle as the third tick
    base = step_cnt;
    bus.confirma = 1'b1;
    cyc(8);
    check("t4_coincide_idx", 64'(bus.msg_idx), 64'd2);
    cyc(1);
    check("t4_coincide_once", 64'(step_cnt - base), 64'd1);
    bus.confirma = 1'b0;
    cyc(9);
    check("t4_tick4_idx", 64'(bus.msg_idx), 64'd0);
    // press mid-period restarts the timer
    bus.confirma = 1'b1;
    cyc(8);
    check("t4_press_idx", 64'(bus.msg_idx), 64'd1);
    cyc(2);
    check("t4_old_slot_idx", 64'(bus.msg_idx), 64'd1);
    check("t4_old_slot_step", 64'(bus.step), 64'd0);
    bus.confirma = 1'b0;
    cyc(7);
    check("t4_restart_before", 64'(bus.msg_idx), 64'd1);
    cyc(1);
    check("t4_restart_tick", 64'(bus.msg_idx), 64'd2);
    bus.auto_mode = 1'b0;
    cyc(15);
    check("t4_auto_off", 64'(bus.msg_idx), 64'd2);

    // 5: out-of-range write ignored, write to shown frame
    bus.wr_en = 1'b1; bus.wr_msg = 2'd3; bus.wr_digit = 3'd0; bus.wr_data = 7'h7F;
    cyc(1);
    bus.wr_en = 1'b0;
    cyc(2);
    check("t5_oob_digits", 64'(bus.digits), 64'd0);
    bus.wr_en = 1'b1; bus.wr_msg = 2'd2; bus.wr_digit = 3'd7; bus.wr_data = 7'h55;
    cyc(1);
    bus.wr_en = 1'b0;
    check("t5_wr_lag", 64'(bus.digits), 64'd0);
    cyc(1);
    check("t5_wr_shown", 64'(bus.digits), 64'h55 << 49);

    // 6: reset mid-debounce and mid-period
    bus.auto_mode = 1'b1;
    bus.confirma  = 1'b1;
    cyc(5);
    reset = 1'b0;
    #1;
    check("t6_rst_idx", 64'(bus.msg_idx), 64'd0);
    check("t6_rst_digits", 64'(bus.digits), 64'd0);
    check("t6_rst_step", 64'(bus.step), 64'd0);
    bus.confirma = 1'b0;
    cyc(2);
    reset = 1'b1;
    base = step_cnt;
    cyc(11);
    check("t6_no_early_tick", 64'(step_cnt - base), 64'd0);
    check("t6_idx_hold", 64'(bus.msg_idx), 64'd0);
    cyc(1);
    check("t6_full_period", 64'(bus.msg_idx), 64'd1);
    cyc(1);
    check("t6_table_cleared", 64'(bus.digits), 64'd0);
    check("t6_one_step", 64'(step_cnt - base), 64'd1);
    bus.auto_mode = 1'b0;
    cyc(5);
    base = step_cnt;
    bus.confirma = 1'b1;
    cyc(3);
    bus.confirma = 1'b0;
    cyc(10);
    check("t6_short_press", 64'(step_cnt - base), 64'd0);
    press_btn();
    check("t6_fresh_press", 64'(bus.msg_idx), 64'd2);
    check("t6_fresh_steps", 64'(step_cnt - base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
